// File: rtl/tap_pkg.sv
// Shared types for the test access port controller: 1149.1 state codes and IR opcodes.
package tap_pkg;

    typedef enum logic [3:0] {
        TLR    = 4'hF,
        RTI    = 4'hC,
        SEL_DR = 4'h7,
        CAP_DR = 4'h6,
        SH_DR  = 4'h2,
        EX1_DR = 4'h1,
        PAU_DR = 4'h3,
        EX2_DR = 4'h0,
        UPD_DR = 4'h5,
        SEL_IR = 4'h4,
        CAP_IR = 4'hE,
        SH_IR  = 4'hA,
        EX1_IR = 4'h9,
        PAU_IR = 4'hB,
        EX2_IR = 4'h8,
        UPD_IR = 4'hD
    } tap_state_t;

    localparam logic [3:0] OP_BYPASS = 4'hF;
    localparam logic [3:0] OP_IDCODE = 4'h1;
    localparam logic [3:0] OP_EXTEST = 4'h0;
    localparam logic [3:0] OP_SAMPLE = 4'h2;

endpackage

// File: rtl/tap_controller_if.sv
// Test-pin and data-register strobe bundle between the pin side (master) and the TAP (slave).
interface tap_controller_if #(
    parameter int IR_WIDTH = 4
);
    // Serial JTAG has no handshake: every rising clk consumes tms/tdi, and tdo is valid for the whole cycle.
    logic                tms;
    logic                tdi;
    logic                dr_tdo;
    logic                tdo;
    logic                tdo_en;
    logic                capture_dr;
    logic                shift_dr;
    logic                update_dr;
    logic [IR_WIDTH-1:0] ir_q;
    logic [3:0]          tap_state;

    modport master (
        output tms, tdi, dr_tdo,
        input  tdo, tdo_en, capture_dr, shift_dr, update_dr, ir_q, tap_state
    );

    modport slave (
        input  tms, tdi, dr_tdo,
        output tdo, tdo_en, capture_dr, shift_dr, update_dr, ir_q, tap_state
    );
endinterface

// File: rtl/tap_fsm.sv
// 16-state 1149.1 TAP state machine: next-state decode of tms and the state register.
module tap_fsm
    import tap_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tms,
    output tap_state_t state
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= TLR;
        end else begin
            case (state)
                TLR:    state <= tms ? TLR    : RTI;
                RTI:    state <= tms ? SEL_DR : RTI;
                SEL_DR: state <= tms ? SEL_IR : CAP_DR;
                CAP_DR: state <= tms ? EX1_DR : SH_DR;
                SH_DR:  state <= tms ? EX1_DR : SH_DR;
                EX1_DR: state <= tms ? UPD_DR : PAU_DR;
                PAU_DR: state <= tms ? EX2_DR : PAU_DR;
                EX2_DR: state <= tms ? UPD_DR : SH_DR;
                UPD_DR: state <= tms ? SEL_DR : RTI;
                SEL_IR: state <= tms ? TLR    : CAP_IR;
                CAP_IR: state <= tms ? EX1_IR : SH_IR;
                SH_IR:  state <= tms ? EX1_IR : SH_IR;
                EX1_IR: state <= tms ? UPD_IR : PAU_IR;
                PAU_IR: state <= tms ? EX2_IR : PAU_IR;
                EX2_IR: state <= tms ? UPD_IR : SH_IR;
                UPD_IR: state <= tms ? SEL_DR : RTI;
                default: state <= TLR;
            endcase
        end
    end

endmodule

// File: rtl/tap_controller.sv
// JTAG TAP controller: owns the instruction and bypass registers, decodes DR strobes and muxes tdo.
module tap_controller
    import tap_pkg::*;
#(
    parameter int                  IR_WIDTH  = 4,
    parameter logic [IR_WIDTH-1:0] IR_RESET  = IR_WIDTH'(OP_IDCODE),
    parameter logic [IR_WIDTH-1:0] IR_BYPASS = '1
) (
    input  logic             clk,
    input  logic             reset,
    tap_controller_if.slave  bus
);

    tap_state_t          state;
    logic [IR_WIDTH-1:0] ir_sr;
    logic [IR_WIDTH-1:0] ir_q;
    logic                bypass;

    tap_fsm u_fsm (
        .clk   (clk),
        .reset (reset),
        .tms   (bus.tms),
        .state (state)
    );

    // Every register acts on the edge leaving the state that owns it, so the
    // case selects on the current state rather than the next one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_sr  <= '0;
            ir_q   <= IR_RESET;
            bypass <= 1'b0;
        end else begin
            case (state)
                CAP_IR:  ir_sr  <= IR_WIDTH'(2'b01);
                SH_IR:   ir_sr  <= {bus.tdi, ir_sr[IR_WIDTH-1:1]};
                UPD_IR:  ir_q   <= ir_sr;
                TLR:     ir_q   <= IR_RESET;
                CAP_DR:  bypass <= 1'b0;
                SH_DR:   bypass <= bus.tdi;
                default: ;
            endcase
        end
    end

    assign bus.capture_dr = (state == CAP_DR);
    assign bus.shift_dr   = (state == SH_DR);
    assign bus.update_dr  = (state == UPD_DR);
    assign bus.tdo_en     = (state == SH_DR) || (state == SH_IR);
    assign bus.ir_q       = ir_q;
    assign bus.tap_state  = state;

    always_comb begin
        bus.tdo = 1'b0;
        if (state == SH_IR) begin
            bus.tdo = ir_sr[0];
        end else if (state == SH_DR) begin
            bus.tdo = (ir_q == IR_BYPASS) ? bypass : bus.dr_tdo;
        end
    end

endmodule

// File: tb/tb_tap_controller.sv
// Self-checking bench for tap_controller: per-cycle reference model plus directed literal checks.
module tb_tap_controller;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    tap_controller_if #(.IR_WIDTH(4)) bus ();

    tap_controller #(
        .IR_WIDTH  (4),
        .IR_RESET  (4'h1),
        .IR_BYPASS (4'hF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad = 0;
    logic [3:0] exp_q[$];

    // Reference model: state transitions from the standard's table, registers as plain arithmetic.
    int nxt0[16];
    int nxt1[16];
    int m_state = 15;
    int m_sr = 0;
    int m_q = 1;
    int m_byp = 0;
    bit chk_en = 1'b1;

    function automatic void chk(string nm, int act, int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, expv, $time);
        end
    endfunction

    function automatic void model_reset();
        m_state = 15; m_sr = 0; m_q = 1; m_byp = 0;
    endfunction

    function automatic void model_edge(input int t, input int d);
        if (m_state == 14) m_sr = 1;
        else if (m_state == 10) m_sr = (m_sr >> 1) + d * 8;
        else if (m_state == 13) m_q = m_sr;
        else if (m_state == 15) m_q = 1;
        else if (m_state == 6) m_byp = 0;
        else if (m_state == 2) m_byp = d;
        m_state = t ? nxt1[m_state] : nxt0[m_state];
    endfunction

    initial begin
        // index = state code; value = next code for tms=0 / tms=1
        nxt0[15] = 12; nxt1[15] = 15;
        nxt0[12] = 12; nxt1[12] = 7;
        nxt0[7]  = 6;  nxt1[7]  = 4;
        nxt0[4]  = 14; nxt1[4]  = 15;
        nxt0[6]  = 2;  nxt1[6]  = 1;
        nxt0[14] = 10; nxt1[14] = 9;
        nxt0[2]  = 2;  nxt1[2]  = 1;
        nxt0[10] = 10; nxt1[10] = 9;
        nxt0[1]  = 3;  nxt1[1]  = 5;
        nxt0[9]  = 11; nxt1[9]  = 13;
        nxt0[3]  = 3;  nxt1[3]  = 0;
        nxt0[11] = 11; nxt1[11] = 8;
        nxt0[0]  = 2;  nxt1[0]  = 5;
        nxt0[8]  = 10; nxt1[8]  = 13;
        nxt0[5]  = 12; nxt1[5]  = 7;
        nxt0[13] = 12; nxt1[13] = 7;
    end

    // Per-cycle compare at the falling edge, using the live dr_tdo input.
    always @(negedge clk) begin
        if (chk_en) begin
            int e_tdo;
            e_tdo = 0;
            if (m_state == 10) e_tdo = m_sr % 2;
            else if (m_state == 2) e_tdo = (m_q == 15) ? m_byp : int'(bus.dr_tdo);
            chk("tap_state", int'(bus.tap_state), m_state);
            chk("ir_q", int'(bus.ir_q), m_q);
            chk("tdo", int'(bus.tdo), e_tdo);
            chk("tdo_en", int'(bus.tdo_en), int'(m_state == 2 || m_state == 10));
            chk("capture_dr", int'(bus.capture_dr), int'(m_state == 6));
            chk("shift_dr", int'(bus.shift_dr), int'(m_state == 2));
            chk("update_dr", int'(bus.update_dr), int'(m_state == 5));
        end
    end

    task automatic step(input logic t, input logic d = 1'b0, input logic r = 1'b0);
        bus.tms = t;
        bus.tdi = d;
        bus.dr_tdo = r;
        @(posedge clk);
        if (reset) model_edge(int'(t), int'(d));
        #1;
    endtask

    // From RTI: load v into ir_q and return to RTI.
    task automatic ir_scan(input logic [3:0] v);
        step(1); step(1); step(0); step(0);
        for (int i = 0; i < 4; i++) step(i == 3, v[i]);
        step(1);
        step(0);
    endtask

    initial begin
        logic [7:0] dvec;
        logic [7:0] rvec;
        logic [3:0] bits;
        int n_shift;
        int n_upd;

        bus.tms = 1'b1; bus.tdi = 1'b0; bus.dr_tdo = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", int'(bus.tap_state), 15);
        chk("reset_ir_q", int'(bus.ir_q), 1);
        reset = 1'b1;

        // 1: five tms=1 hold TLR with all strobes idle
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("t1_strobes", int'({bus.capture_dr, bus.shift_dr, bus.update_dr, bus.tdo_en}), 0);
        end
        chk("t1_state", int'(bus.tap_state), 15);
        chk("t1_ir_q", int'(bus.ir_q), 1);

        // 2: IR scan shifting 0,1,0,0 -> tdo 1,0,0,0, ir_q = 2
        step(0);
        chk("t2_rti", int'(bus.tap_state), 12);
        step(1); step(1); step(0); step(0);
        chk("t2_shir", int'(bus.tap_state), 10);
        exp_q = '{4'd1, 4'd0, 4'd0, 4'd0};
        bits = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            chk("t2_tdo", int'(bus.tdo), int'(exp_q.pop_front()));
            step(i == 3, bits[i]);
        end
        step(1);
        chk("t2_updir", int'(bus.tap_state), 13);
        step(0);
        chk("t2_ir_q", int'(bus.ir_q), 2);

        // 3: bypass DR scan, tdo = tdi delayed one clock, first bit 0
        ir_scan(4'hF);
        chk("t3_ir_q", int'(bus.ir_q), 15);
        dvec = 8'b01011100;
        step(1); step(0); step(0);
        for (int i = 0; i < 8; i++) begin
            chk("t3_bypass_tdo", int'(bus.tdo), (i == 0) ? 0 : int'(dvec[i-1]));
            step(i == 7, dvec[i]);
        end
        step(1); step(0);

        // 4: non-bypass DR scan, tdo follows dr_tdo; strobe widths
        ir_scan(4'h2);
        rvec = 8'b10100011;
        n_shift = 0;
        n_upd = 0;
        step(1);
        step(0);
        chk("t4_capture", int'(bus.capture_dr), 1);
        step(0);
        n_shift += int'(bus.shift_dr);
        for (int i = 0; i < 8; i++) begin
            bus.dr_tdo = rvec[i];
            #1;
            chk("t4_tdo_mirror", int'(bus.tdo), int'(rvec[i]));
            step(i == 7, 1'b0, rvec[i]);
            n_shift += int'(bus.shift_dr);
            n_upd += int'(bus.update_dr);
        end
        step(1);
        n_upd += int'(bus.update_dr);
        step(0);
        n_upd += int'(bus.update_dr);
        chk("t4_shift_cycles", n_shift, 8);
        chk("t4_update_cycles", n_upd, 1);

        // 5: IR scan split by a three-cycle pause: bits 1,0,1,1 -> ir_q = D
        bits = 4'b1101;
        step(1); step(1); step(0); step(0);
        step(0, bits[0]); step(1, bits[1]);
        step(0);
        chk("t5_pause", int'(bus.tap_state), 11);
        step(0); step(0);
        step(1); step(0);
        chk("t5_resume", int'(bus.tap_state), 10);
        step(0, bits[2]); step(1, bits[3]);
        step(1); step(0);
        chk("t5_ir_q", int'(bus.ir_q), 13);

        // 6: async reset in Shift-DR, then random tms against the model
        step(1); step(0); step(0); step(0, 1'b1);
        chk("t6_in_shdr", int'(bus.tap_state), 2);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("t6_async_state", int'(bus.tap_state), 15);
        chk("t6_async_tdo_en", int'(bus.tdo_en), 0);
        chk("t6_async_ir_q", int'(bus.ir_q), 1);
        @(posedge clk);
        #1;
        chk("t6_no_update", int'(bus.update_dr), 0);
        reset = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 5; i++) step(1);
        chk("t6_five_ones_tlr", int'(bus.tap_state), 15);

        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
